// File: rtl/lfsr_run_ctrl.sv
// Run sequencer: programs the generator seed over AXI-Lite, optionally verifies it by readback,
// then forwards num_samples AXI-Stream beats to the binner. Readback is enabled by RUN_CTRL_READBACK_EN.
module lfsr_run_ctrl #(
  parameter logic [31:0] SEED_ADDR = 32'h0000_0008,
  parameter int          CNT_W     = 16,
  parameter int          TIMEOUT   = 255
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [31:0]      seed_in,
  input  logic [CNT_W-1:0] num_samples,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      m_axil_awaddr,
  output logic             m_axil_awvalid,
  input  logic             m_axil_awready,
  output logic [31:0]      m_axil_wdata,
  output logic             m_axil_wvalid,
  input  logic             m_axil_wready,
  input  logic [1:0]       m_axil_bresp,
  input  logic             m_axil_bvalid,
  output logic             m_axil_bready,
  output logic [31:0]      m_axil_araddr,
  output logic             m_axil_arvalid,
  input  logic             m_axil_arready,
  input  logic [31:0]      m_axil_rdata,
  input  logic [1:0]       m_axil_rresp,
  input  logic             m_axil_rvalid,
  output logic             m_axil_rready,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [31:0]      sample_data,
  output logic             sample_valid,
  output logic [CNT_W-1:0] sample_count
);

`ifdef RUN_CTRL_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE     = 1;

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // every valid/ready this block drives is registered and derived from the next state.
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_STREAM, S_FIN
  } state_t;

  state_t           state, state_next, post_ok;
  logic [CNT_W-1:0] num_q;
  logic [7:0]       timer;
  logic             aw_done, w_done;
  logic             aw_acc, w_acc, beat, last_beat, rd_fail;
  logic             waiting, timed_out, err_set;

  always_comb begin
    aw_acc    = m_axil_awvalid & m_axil_awready;
    w_acc     = m_axil_wvalid & m_axil_wready;
    beat      = s_axis_tvalid & s_axis_tready;
    last_beat = beat && (sample_count == num_q - ONE);
    rd_fail   = (m_axil_rresp != 2'b00) || (m_axil_rdata != m_axil_wdata);
    post_ok   = (num_q == '0) ? S_FIN : S_STREAM;

    // The timer tracks consecutive cycles in which the awaited event is absent.
    waiting = 1'b0;
    case (state)
      S_WR:      waiting = !(aw_acc | w_acc);
      S_WR_RESP: waiting = !m_axil_bvalid;
      S_RD_ADDR: waiting = !m_axil_arready;
      S_RD_DATA: waiting = !m_axil_rvalid;
      S_STREAM:  waiting = !s_axis_tvalid;
      default:   waiting = 1'b0;
    endcase
    timed_out = waiting && (timer == TO_LAST);

    state_next = state;
    err_set    = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_WR;
      S_WR: begin
        if (timed_out) begin
          err_set    = 1'b1;
          state_next = S_FIN;
        end else if ((aw_done | aw_acc) && (w_done | w_acc)) begin
          state_next = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid && m_axil_bready) begin
          if (m_axil_bresp == 2'b00) begin
            state_next = READBACK ? S_RD_ADDR : post_ok;
          end else begin
            err_set    = 1'b1;
            state_next = S_FIN;
          end
        end else if (timed_out) begin
          err_set    = 1'b1;
          state_next = S_FIN;
        end
      end
      S_RD_ADDR: begin
        if (m_axil_arready && m_axil_arvalid) state_next = S_RD_DATA;
        else if (timed_out) begin
          err_set    = 1'b1;
          state_next = S_FIN;
        end
      end
      S_RD_DATA: begin
        if (m_axil_rvalid && m_axil_rready) begin
          if (rd_fail) begin
            err_set    = 1'b1;
            state_next = S_FIN;
          end else begin
            state_next = post_ok;
          end
        end else if (timed_out) begin
          err_set    = 1'b1;
          state_next = S_FIN;
        end
      end
      S_STREAM: begin
        if (last_beat) state_next = S_FIN;
        else if (timed_out) begin
          err_set    = 1'b1;
          state_next = S_FIN;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      timer          <= 8'd0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      num_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      m_axil_awaddr  <= 32'd0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= 32'd0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= 32'd0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      s_axis_tready  <= 1'b0;
      sample_data    <= 32'd0;
      sample_valid   <= 1'b0;
      sample_count   <= '0;
    end else begin
      state   <= state_next;
      timer   <= ((state_next != state) || !waiting) ? 8'd0 : timer + 8'd1;
      aw_done <= (state == S_WR) && (aw_done | aw_acc);
      w_done  <= (state == S_WR) && (w_done | w_acc);

      // Both valids rise together on WR entry; each then falls after its own acceptance.
      m_axil_awvalid <= (state_next == S_WR) && !(aw_done | aw_acc);
      m_axil_wvalid  <= (state_next == S_WR) && !(w_done | w_acc);
      m_axil_bready  <= (state_next == S_WR_RESP);
      m_axil_arvalid <= READBACK && (state_next == S_RD_ADDR);
      m_axil_rready  <= READBACK && (state_next == S_RD_DATA);
      s_axis_tready  <= (state_next == S_STREAM);
      busy           <= (state_next != S_IDLE);
      done           <= (state_next == S_FIN);

      if (state == S_IDLE && start) begin
        m_axil_wdata  <= seed_in;
        m_axil_awaddr <= SEED_ADDR;
        m_axil_araddr <= SEED_ADDR;
        num_q         <= num_samples;
        error         <= 1'b0;
        sample_count  <= '0;
      end else begin
        if (err_set) error <= 1'b1;
        if (beat) sample_count <= sample_count + ONE;
      end

      sample_valid <= beat;
      if (beat) sample_data <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Self-checking bench for lfsr_run_ctrl: randomized AXI-Lite/AXI-Stream slave, scoreboard on the
// sample forward path, and a run-outcome model derived from the slave configuration.
module tb_lfsr_run_ctrl;
  localparam int CNT_W = 16;

`ifdef RUN_CTRL_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      seed_in = 32'd0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             busy, done, error;
  logic [31:0]      m_axil_awaddr, m_axil_wdata, m_axil_araddr;
  logic             m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic             m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_arready, m_axil_rvalid;
  logic [1:0]       m_axil_bresp, m_axil_rresp;
  logic [31:0]      m_axil_rdata, s_axis_tdata, sample_data;
  logic             s_axis_tvalid, s_axis_tready, sample_valid;
  logic [CNT_W-1:0] sample_count;

  always #5 aclk = ~aclk;

  lfsr_run_ctrl #(.SEED_ADDR(32'h0000_0008), .CNT_W(CNT_W), .TIMEOUT(255)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .seed_in(seed_in), .num_samples(num_samples),
    .busy(busy), .done(done), .error(error),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid),
    .m_axil_rready(m_axil_rready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_count(sample_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // slave configuration
  int         p_rdy = 100, p_tv = 100;
  bit         stall_tv = 0, b_hold = 0, rdata_bad = 0;
  logic [1:0] bresp_cfg = 2'b00;

  // slave observation log
  int          aw_cnt, w_cnt, ar_cnt, beat_cnt, sv_cnt, stall_run, sv_run, sv_run_max;
  bit          tready_seen;
  logic [31:0] last_awaddr, last_wdata, reg_val;
  logic [31:0] exp_q[$];

  // slave: drives at negedge, then records which handshakes will complete at the next posedge
  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, t_hs, aw_got, w_got, b_pend, r_pend, wv_prev;
    logic [31:0] aw_s, w_s, t_s, got;
    {aw_hs, w_hs, b_hs, ar_hs, r_hs, t_hs, aw_got, w_got, b_pend, r_pend, wv_prev} = '0;
    {m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_arready, m_axil_rvalid, s_axis_tvalid} = '0;
    m_axil_bresp = 2'b00; m_axil_rresp = 2'b00; m_axil_rdata = 32'd0; s_axis_tdata = 32'd0;
    reg_val = 32'd0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, t_hs, aw_got, w_got, b_pend, r_pend, wv_prev} = '0;
        {m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_arready, m_axil_rvalid, s_axis_tvalid} = '0;
        continue;
      end
      if (aw_hs) begin aw_cnt++; last_awaddr = aw_s; aw_got = 1; end
      if (w_hs) begin w_cnt++; last_wdata = w_s; reg_val = w_s; w_got = 1; end
      if (aw_got && w_got && !b_pend) begin b_pend = 1; aw_got = 0; w_got = 0; end
      if (b_hs) b_pend = 0;
      if (ar_hs) begin ar_cnt++; r_pend = 1; end
      if (r_hs) r_pend = 0;
      if (t_hs) begin beat_cnt++; exp_q.push_back(t_s); end
      if (sample_valid) begin
        vectors++; sv_cnt++; sv_run++;
        if (sv_run > sv_run_max) sv_run_max = sv_run;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL sample_unexpected: sample_data %h with no accepted beat", sample_data);
        end else begin
          got = exp_q.pop_front();
          if (sample_data !== got) begin
            miscompares++; $display("FAIL sample_data: got %h want %h", sample_data, got);
          end
        end
      end else sv_run = 0;
      if (m_axil_wvalid && !wv_prev) begin
        vectors++;
        if (!m_axil_awvalid) begin
          miscompares++; $display("FAIL wvalid_alone: wvalid rose with awvalid=%b", m_axil_awvalid);
        end
      end
      wv_prev = m_axil_wvalid;
      if (s_axis_tready) tready_seen = 1;

      m_axil_awready = ($urandom_range(1, 100) <= p_rdy);
      m_axil_wready  = ($urandom_range(1, 100) <= p_rdy);
      m_axil_arready = ($urandom_range(1, 100) <= p_rdy);
      m_axil_bvalid  = b_pend && !b_hold;
      m_axil_bresp   = bresp_cfg;
      m_axil_rvalid  = r_pend;
      m_axil_rdata   = rdata_bad ? 32'd0 : reg_val;
      if (stall_tv) s_axis_tvalid = 1'b0;
      else if (!(s_axis_tvalid && !t_hs)) begin
        s_axis_tvalid = ($urandom_range(1, 100) <= p_tv);
        s_axis_tdata  = $urandom;
      end

      aw_hs = m_axil_awvalid && m_axil_awready; aw_s = m_axil_awaddr;
      w_hs  = m_axil_wvalid && m_axil_wready;   w_s  = m_axil_wdata;
      b_hs  = m_axil_bvalid && m_axil_bready;
      ar_hs = m_axil_arvalid && m_axil_arready;
      r_hs  = m_axil_rvalid && m_axil_rready;
      t_hs  = s_axis_tvalid && s_axis_tready;   t_s  = s_axis_tdata;
      if (s_axis_tready && !s_axis_tvalid) stall_run++;
      else stall_run = 0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge aclk); #1; end
  endtask

  task automatic clear_log();
    {aw_cnt, w_cnt, ar_cnt, beat_cnt, sv_cnt, sv_run, sv_run_max} = '0;
    tready_seen = 0; last_awaddr = 32'hx; last_wdata = 32'hx;
    exp_q.delete();
  endtask

  // Expected run outcome from the slave configuration alone.
  task automatic model(input logic [31:0] seed, input logic [CNT_W-1:0] num,
                       output bit e_err, output int e_beats, output int e_ar, output bit e_tr);
    bit wr_ok, rb_ok, stream;
    wr_ok   = (bresp_cfg == 2'b00) && !b_hold;
    rb_ok   = !RB_EN || !rdata_bad || (seed == 32'd0);
    stream  = wr_ok && rb_ok && (num != 0);
    e_err   = !wr_ok || !rb_ok || (stream && stall_tv);
    e_beats = (stream && !stall_tv) ? int'(num) : 0;
    e_ar    = (RB_EN && wr_ok) ? 1 : 0;
    e_tr    = stream;
  endtask

  // Pulses start, optionally re-pulses it mid-run at cycle 'poke', and waits for done.
  task automatic do_run(input logic [31:0] seed, input logic [CNT_W-1:0] num, input int poke,
                        output bit err, output logic [CNT_W-1:0] cnt, output int stall_at);
    bit got_done = 0;
    clear_log();
    seed_in = seed; num_samples = num; start = 1;
    tick(1);
    start = 0; seed_in = ~seed; num_samples = num + 16'd3;
    vectors++;
    if ({busy, m_axil_awvalid, m_axil_wvalid} !== 3'b111) begin
      miscompares++; $display("FAIL start_latency: busy/awvalid/wvalid=%b want 111", {busy, m_axil_awvalid, m_axil_wvalid});
    end
    err = 1'bx; cnt = 'x; stall_at = -1;
    for (int c = 1; c < 3000; c++) begin
      if (done) begin got_done = 1; err = error; cnt = sample_count; stall_at = stall_run; break; end
      if (c == poke) start = 1;
      tick(1);
      start = 0;
    end
    vectors++;
    if (!got_done) begin
      miscompares++; $display("FAIL run_done_timeout: done=%b after 3000 cycles, want 1", done);
    end else begin
      tick(1);
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++; $display("FAIL done_pulse: done/busy=%b one cycle later, want 00", {done, busy});
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 0; tick(3);
    vectors++;
    if ({busy, done, error, sample_valid, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
         m_axil_rready, s_axis_tready, m_axil_awaddr, m_axil_araddr, m_axil_wdata, sample_data, sample_count} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: busy=%b done=%b error=%b cnt=%0d awaddr=%h wdata=%h, want all 0",
                              busy, done, error, sample_count, m_axil_awaddr, m_axil_wdata);
    end
    aresetn = 1; tick(2);
  endtask

  task automatic test_nominal();
    bit err; logic [CNT_W-1:0] cnt; int st;
    p_rdy = 100; p_tv = 100;
    do_run(32'h1234_5678, 16'd4, -1, err, cnt, st);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL nominal_err: got %b want 0", err); end
    vectors++; if (cnt !== 16'd4) begin miscompares++; $display("FAIL nominal_count: got %0d want 4", cnt); end
    vectors++; if (sv_cnt != 4) begin miscompares++; $display("FAIL nominal_pulses: got %0d want 4", sv_cnt); end
    vectors++; if (aw_cnt != 1 || last_awaddr !== 32'h8) begin
      miscompares++; $display("FAIL nominal_aw: count %0d addr %h want 1 / 00000008", aw_cnt, last_awaddr); end
    vectors++; if (last_wdata !== 32'h1234_5678) begin
      miscompares++; $display("FAIL nominal_wdata: got %h want 12345678", last_wdata); end
    vectors++; if (ar_cnt != (RB_EN ? 1 : 0)) begin
      miscompares++; $display("FAIL nominal_ar: got %0d want %0d", ar_cnt, RB_EN ? 1 : 0); end
  endtask

  task automatic test_write_error();
    bit err; logic [CNT_W-1:0] cnt; int st;
    bresp_cfg = 2'b10;
    do_run(32'hCAFE_0001, 16'd4, -1, err, cnt, st);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wrerr_err: got %b want 1", err); end
    vectors++; if (ar_cnt != 0) begin miscompares++; $display("FAIL wrerr_ar: got %0d want 0", ar_cnt); end
    vectors++; if (tready_seen) begin miscompares++; $display("FAIL wrerr_tready: tready seen, want never"); end
    tick(3);
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL wrerr_hold: error=%b want 1", error); end
    bresp_cfg = 2'b00;
  endtask

  task automatic test_readback_mismatch();
    bit err; logic [CNT_W-1:0] cnt; int st;
    rdata_bad = 1;
    do_run(32'hA5A5_A5A5, 16'd4, -1, err, cnt, st);
    vectors++; if (err !== RB_EN) begin miscompares++; $display("FAIL rb_err: got %b want %b", err, RB_EN); end
    vectors++; if (cnt !== (RB_EN ? 16'd0 : 16'd4)) begin
      miscompares++; $display("FAIL rb_count: got %0d want %0d", cnt, RB_EN ? 0 : 4); end
    rdata_bad = 0;
  endtask

  task automatic test_stall_timeout();
    bit err; logic [CNT_W-1:0] cnt; int st;
    stall_tv = 1;
    do_run(32'h0BAD_F00D, 16'd4, -1, err, cnt, st);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL stall_err: got %b want 1", err); end
    vectors++; if (st != 255) begin miscompares++; $display("FAIL stall_cycles: done after %0d stalls want 255", st); end
    vectors++; if (cnt !== 16'd0) begin miscompares++; $display("FAIL stall_count: got %0d want 0", cnt); end
    tick(40);
    vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL stall_tready: got %b want 0", s_axis_tready); end
    stall_tv = 0;
  endtask

  task automatic test_handshake_timeout();
    bit err; logic [CNT_W-1:0] cnt; int st;
    b_hold = 1;
    do_run(32'h7777_1111, 16'd4, -1, err, cnt, st);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bto_err: got %b want 1", err); end
    vectors++; if (ar_cnt != 0 || tready_seen) begin
      miscompares++; $display("FAIL bto_progress: ar %0d tready_seen %b want 0/0", ar_cnt, tready_seen); end
    b_hold = 0;
  endtask

  task automatic test_zero_samples();
    bit err; logic [CNT_W-1:0] cnt; int st;
    do_run(32'h0000_00FF, 16'd0, -1, err, cnt, st);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL zero_err: got %b want 0", err); end
    vectors++; if (tready_seen || cnt !== 16'd0) begin
      miscompares++; $display("FAIL zero_stream: tready_seen %b count %0d want 0/0", tready_seen, cnt); end
  endtask

  task automatic test_start_while_busy();
    bit err; logic [CNT_W-1:0] cnt; int st; logic [31:0] seed;
    int pokes[2] = '{2, 12};
    for (int k = 0; k < 2; k++) begin
      seed = $urandom;
      do_run(seed, 16'd9, pokes[k], err, cnt, st);
      tick(4);
      vectors++; if (last_wdata !== seed || aw_cnt != 1) begin
        miscompares++; $display("FAIL busy_start_seed: wdata %h writes %0d want %h / 1", last_wdata, aw_cnt, seed); end
      vectors++; if (cnt !== 16'd9 || sample_count !== 16'd9) begin
        miscompares++; $display("FAIL busy_start_count: got %0d/%0d want 9", cnt, sample_count); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit err, seen = 0; logic [CNT_W-1:0] cnt; int st;
    clear_log(); b_hold = 1;
    seed_in = 32'h5555_AAAA; num_samples = 16'd5; start = 1;
    tick(1); start = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (m_axil_bready) seen = 1; else tick(1);
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL midrst_reach: bready=%b want 1 within 50", m_axil_bready); end
    aresetn = 0; tick(1);
    vectors++;
    if ({busy, done, error, sample_valid, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
         m_axil_rready, s_axis_tready, m_axil_awaddr, m_axil_araddr, m_axil_wdata, sample_data, sample_count} !== '0) begin
      miscompares++; $display("FAIL midrst_outputs: busy=%b bready=%b awaddr=%h wdata=%h, want all 0",
                              busy, m_axil_bready, m_axil_awaddr, m_axil_wdata);
    end
    aresetn = 1; b_hold = 0; tick(2);
    do_run(32'h1357_9BDF, 16'd5, -1, err, cnt, st);
    vectors++; if (err !== 1'b0 || cnt !== 16'd5) begin
      miscompares++; $display("FAIL midrst_rerun: err %b count %0d want 0/5", err, cnt); end
  endtask

  task automatic test_back_to_back();
    bit err; logic [CNT_W-1:0] cnt; int st;
    p_rdy = 100; p_tv = 100;
    do_run($urandom, 16'd32, -1, err, cnt, st);
    vectors++; if (err !== 1'b0 || cnt !== 16'd32) begin
      miscompares++; $display("FAIL b2b_run: err %b count %0d want 0/32", err, cnt); end
    vectors++; if (sv_run_max != 32) begin
      miscompares++; $display("FAIL b2b_rate: longest sample_valid run %0d want 32", sv_run_max); end
  endtask

  task automatic test_random();
    bit err, e_err, e_tr; logic [CNT_W-1:0] cnt, num; int st, e_beats, e_ar; logic [31:0] seed;
    for (int r = 0; r < 12; r++) begin
      p_rdy = $urandom_range(30, 100); p_tv = $urandom_range(30, 100);
      bresp_cfg = ($urandom_range(1, 5) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      rdata_bad = ($urandom_range(1, 5) == 1);
      seed = $urandom; num = 16'($urandom_range(1, 40));
      model(seed, num, e_err, e_beats, e_ar, e_tr);
      do_run(seed, num, -1, err, cnt, st);
      tick(2);
      vectors++; if (err !== e_err) begin miscompares++; $display("FAIL rand_err[%0d]: got %b want %b", r, err, e_err); end
      vectors++; if (int'(cnt) != e_beats || sv_cnt != e_beats) begin
        miscompares++; $display("FAIL rand_beats[%0d]: count %0d pulses %0d want %0d", r, cnt, sv_cnt, e_beats); end
      vectors++; if (ar_cnt != e_ar || tready_seen != e_tr) begin
        miscompares++; $display("FAIL rand_flow[%0d]: ar %0d tready %b want %0d/%b", r, ar_cnt, tready_seen, e_ar, e_tr); end
      vectors++; if (last_wdata !== seed) begin
        miscompares++; $display("FAIL rand_wdata[%0d]: got %h want %h", r, last_wdata, seed); end
    end
    p_rdy = 100; p_tv = 100; bresp_cfg = 2'b00; rdata_bad = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_write_error();
    test_readback_mismatch();
    test_stall_timeout();
    test_handshake_timeout();
    test_zero_samples();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
